zero_run_monitor: RTL
=====================

// Module: zero_run_monitor
// PURPOSE
//  Downstream consumer of zero_detector's y_out. Measures the length, in CLOCK
//  cycles, of each contiguous y_out-high run. Counts detection events, tracks
//  the longest run and raises a long-run alarm. Presents each completed run
//  length through a valid/ack readout handshake to the host or bench.
// PARAMETERS
//  RUN_W      8   width of run_len, max_run and the internal run counter
//  EVT_W      8   width of event_cnt
//  ALARM_LEN  16  run length (cycles) at which alarm asserts; 1..2^RUN_W-1
// PORTS
//  CLOCK      in   1      single clock, all logic on rising edge
//  t_reset    in   1      synchronous reset, active-high
//  det_in     in   1      y_out from zero_detector
//  rd_ack     in   1      host accepts run_len; effective only while run_valid=1
//  clr        in   1      sync clear of event_cnt, max_run, overrun
//  run_len    out  RUN_W  length of last accepted completed run
//  run_valid  out  1      run_len holds an unread result
//  event_cnt  out  EVT_W  number of runs started, modulo 2^EVT_W
//  max_run    out  RUN_W  longest completed run since reset/clr
//  overrun    out  1      sticky: a run completed while run_valid=1 and no ack
//  alarm      out  1      current run counter >= ALARM_LEN
// BEHAVIOUR
//  - Reset: t_reset=1 at a CLOCK edge forces every output to 0, the counter to 0
//    and the FSM to IDLE. Reset overrides clr, rd_ack and det_in, mid-run included.
//  - FSM states: IDLE, RUN, SAT. All outputs are registered.
//    IDLE: det_in=1 -> RUN, cnt<=1, event_cnt<=event_cnt+1 (wraps).
//    RUN: det_in=1 -> cnt<=cnt+1; at cnt=2^RUN_W-2 the next high edge loads
//      the max value and moves to SAT. det_in=0 -> complete, IDLE.
//    SAT: cnt holds at 2^RUN_W-1 while det_in=1. det_in=0 -> complete, IDLE.
//  - Run length = number of edges at which det_in is sampled 1. A 1-cycle pulse
//    gives 1. Runs need an intervening 0 sample; there is no back-to-back merge.
//  - Complete (the edge that first samples det_in=0 after a run):
//    - if run_valid=0 or rd_ack=1: run_len<=cnt, run_valid<=1. This includes
//      the simultaneous-ack case, where the old value is consumed and the new
//      one loaded.
//    - else: run_len unchanged, overrun<=1, and the new length is dropped.
//    - max_run<=cnt if cnt>max_run. This applies even when the length is dropped.
//    - cnt<=0.
//  - Result latency: run_valid is visible 1 cycle after the last high sample.
//  - Handshake: run_valid=1 and rd_ack=1 with no completion on that edge ->
//    run_valid<=0. rd_ack while run_valid=0 is ignored.
//  - alarm: registered compare, alarm<=(next cnt>=ALARM_LEN). It rises on the
//    edge where cnt reaches ALARM_LEN and falls on the completion edge.
//  - clr=1: event_cnt, max_run, overrun <=0. A run start on the same edge is
//    counted, leaving event_cnt=1. A completion on the same edge is cleared,
//    leaving max_run=0 and overrun=0, but run_len and run_valid still update.
//    clr never touches cnt, run_len, run_valid or the FSM.
// TESTING (CLOCK period 10, edges at 5,15,25,...; defaults unless stated)
//  1. t_reset=1 for the first 2 edges, det_in=0 -> all outputs 0 and FSM in
//     IDLE; then t_reset=0 and det_in high for 3 edges -> run_len=3,
//     run_valid=1, event_cnt=1, max_run=3.
//  2. Runs of 5 then 2 cycles, rd_ack pulsed after each result -> run_len 5
//     then 2, max_run stays 5, run_valid drops the edge after each ack,
//     event_cnt=2.
//  3. Run of 4 left unacked, then a run of 6 -> overrun=1, run_len=4,
//     max_run=6. Then rd_ack -> run_valid=0. Then clr -> overrun=0, max_run=0,
//     event_cnt=0.
//  4. rd_ack asserted on the completion edge of a run of 7 while run_valid=1 ->
//     run_len=7, run_valid stays 1, overrun stays 0.
//  5. det_in high for 20 edges -> alarm rises after edge 16 and falls on the
//     completion edge. With RUN_W=4, 20 high edges -> run_len=15 (SAT).
//  6. t_reset asserted mid-run at cnt=3 -> all outputs 0. The next det_in pulse
//     of 2 cycles gives run_len=2 and event_cnt=1.

Source files
------------

// File: rtl/zero_run_monitor.sv
// ---------------------------------------------------------------------------
// zero_run_monitor
//   Measures the length, in CLOCK cycles, of each contiguous det_in-high run
//   coming from zero_detector. It counts run starts, tracks the longest run,
//   raises an alarm while the current run is long, and holds each completed
//   length for the host through a valid/ack readout.
//
// Ports
//   CLOCK      in   1      single clock, rising edge
//   t_reset    in   1      synchronous reset, active-high
//   det_in     in   1      y_out from zero_detector
//   rd_ack     in   1      host accepts run_len (ignored while run_valid=0)
//   clr        in   1      sync clear of event_cnt, max_run, overrun
//   run_len    out  RUN_W  length of last accepted completed run
//   run_valid  out  1      run_len holds an unread result
//   event_cnt  out  EVT_W  runs started, modulo 2^EVT_W
//   max_run    out  RUN_W  longest completed run since reset/clr
//   overrun    out  1      sticky: a completed run was dropped
//   alarm      out  1      current run counter >= ALARM_LEN
// ---------------------------------------------------------------------------
module zero_run_monitor #(
    parameter int RUN_W     = 8,
    parameter int EVT_W     = 8,
    parameter int ALARM_LEN = 16
) (
    input  logic             CLOCK,
    input  logic             t_reset,
    input  logic             det_in,
    input  logic             rd_ack,
    input  logic             clr,
    output logic [RUN_W-1:0] run_len,
    output logic             run_valid,
    output logic [EVT_W-1:0] event_cnt,
    output logic [RUN_W-1:0] max_run,
    output logic             overrun,
    output logic             alarm
);

    localparam logic [RUN_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] ALARM_V = RUN_W'(ALARM_LEN);

    typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] cnt, cnt_nxt;

    logic             start, complete, accept;
    logic [RUN_W-1:0] run_len_nxt, max_run_nxt;
    logic [EVT_W-1:0] event_cnt_nxt;
    logic             run_valid_nxt, overrun_nxt, alarm_nxt;

    // State register
    always_ff @(posedge CLOCK) begin
        if (t_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and run counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (det_in) begin
                state_nxt = (CNT_MAX == RUN_W'(1)) ? SAT : RUN;
                cnt_nxt   = RUN_W'(1);
            end
            RUN: if (det_in) begin
                cnt_nxt = cnt + RUN_W'(1);
                // cnt+1 reaching all-ones means the counter is now pinned
                if (cnt == CNT_MAX - RUN_W'(1)) state_nxt = SAT;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            SAT: if (!det_in) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output next-values
    always_comb begin
        start    = (state == IDLE) && det_in;
        complete = (state != IDLE) && !det_in;
        // A simultaneous ack frees the slot for the new result
        accept   = complete && (!run_valid || rd_ack);

        run_len_nxt   = accept ? cnt : run_len;
        run_valid_nxt = run_valid;
        if (accept)                 run_valid_nxt = 1'b1;
        else if (run_valid && rd_ack) run_valid_nxt = 1'b0;

        event_cnt_nxt = event_cnt;
        max_run_nxt   = max_run;
        overrun_nxt   = overrun;
        if (clr) begin
            // A run start on the clearing edge still counts
            event_cnt_nxt = start ? EVT_W'(1) : '0;
            max_run_nxt   = '0;
            overrun_nxt   = 1'b0;
        end else begin
            if (start)                     event_cnt_nxt = event_cnt + EVT_W'(1);
            if (complete && cnt > max_run) max_run_nxt   = cnt;
            if (complete && !accept)       overrun_nxt   = 1'b1;
        end

        alarm_nxt = (cnt_nxt >= ALARM_V);
    end

    // Registered datapath and outputs
    always_ff @(posedge CLOCK) begin
        if (t_reset) begin
            cnt       <= '0;
            run_len   <= '0;
            run_valid <= 1'b0;
            event_cnt <= '0;
            max_run   <= '0;
            overrun   <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            run_len   <= run_len_nxt;
            run_valid <= run_valid_nxt;
            event_cnt <= event_cnt_nxt;
            max_run   <= max_run_nxt;
            overrun   <= overrun_nxt;
            alarm     <= alarm_nxt;
        end
    end

endmodule
